mat_mul_sched: RTL and testbench
================================

// Module: mat_mul_sched
// PURPOSE
//  Round-robin scheduler sharing one mat_mul engine among NUM_REQ requesters.
//  - Queues single-cycle job requests.
//  - Latches the granted requester's operands and issues a one-cycle start to the engine.
//  - Waits for engine done, captures C and acknowledges the requester.
//  - A watchdog aborts jobs whose done never arrives.
// PARAMETERS
//  DATA_LEN  32    element width, signed two's complement
//  M/N/K     8     matrix dimensions; MAT_SIZE = DATA_LEN*M*K = 2048 bits per matrix
//  NUM_REQ   2     number of requesters, 2..4
//  TIMEOUT   256   max WAIT cycles before abort, >=2
// PORTS
//  i_clk       in   1                 clock
//  i_rst       in   1                 synchronous reset, active-high
//  i_req       in   NUM_REQ           per-requester job pulse, one cycle
//  i_req_mat_a in   NUM_REQ*MAT_SIZE  A operands; slice r = [r*MAT_SIZE +: MAT_SIZE]
//  i_req_mat_b in   NUM_REQ*MAT_SIZE  B operands; same slicing as A
//  o_grant     out  NUM_REQ           one-hot owner during START/WAIT; 0 otherwise
//  o_done      out  NUM_REQ           one-cycle completion pulse to owner
//  o_err       out  NUM_REQ           one-cycle timeout pulse; coincides with o_done
//  o_mat_c     out  MAT_SIZE          last captured result
//  o_busy      out  1                 high whenever state != IDLE
//  o_mm_start  out  1                 engine start pulse
//  o_mm_mat_a  out  MAT_SIZE          registered A to engine
//  o_mm_mat_b  out  MAT_SIZE          registered B to engine
//  i_mm_done   in   1                 engine done
//  i_mm_mat_c  in   MAT_SIZE          engine result
// BEHAVIOUR
//  Reset
//   - All outputs 0, pending=0, state=IDLE, rr pointer=0, timer=0.
//   - Reset mid-job abandons the job: no o_done, no o_err.
//   - The engine is not reset by this block.
//  Pending
//   - i_req[r] sets pend[r] next cycle; the grant clears it.
//   - Set and clear in the same cycle: set wins; the job is queued again.
//   - A repeat pulse while pend[r]=1 is absorbed: no counting.
//  FSM
//   IDLE
//    - If pend != 0: pick the first set bit at or after ptr, wrapping.
//    - Register A/B slices, o_grant=onehot(g) and ptr=g+1 mod NUM_REQ; go to START.
//   START
//    - o_mm_start=1 for exactly this cycle; timer=0; go to WAIT.
//   WAIT
//    - Timer increments each cycle.
//    - On i_mm_done: o_mat_c<=i_mm_mat_c, o_done[g]=1, go to IDLE.
//    - Else on timer==TIMEOUT-1: o_err[g]=1 and o_done[g]=1; o_mat_c unchanged; go to IDLE.
//    - If done and timeout fall on the same cycle, done wins and o_err stays 0.
//  Ignored inputs
//   - i_mm_done outside WAIT is ignored.
//   - i_req_mat_* changes after grant do not affect the running job.
//  Latency
//   - From an idle block, an i_req pulse at cycle t gives o_mm_start at t+2.
//   - o_done follows i_mm_done by 1 cycle; o_grant drops in the same cycle.
//   - Back-to-back jobs: IDLE lasts 1 cycle between jobs.
//  Width/value rules
//   - The block does no arithmetic on data; values pass through unchanged.
//   - Counter width is $clog2(TIMEOUT).
// STRUCTURE
//  - mat_mul_pkg holds DATA_LEN, M, N, K, ROW_SIZE, MAT_SIZE and the state encodings:
//    IDLE=2'd0, START=2'd1, WAIT=2'd2.
//  - Sub-module rr_arbiter: pend + ptr in, one-hot grant and next ptr out; purely combinational.
//  - The top level holds the FSM, operand/result registers and the watchdog.
// TESTING
//  - Reset, then i_req=01 with A=all 1, B row k=k, on the real mat_mul:
//    o_mm_start at t+2, o_done=01, every C element=28.
//  - Rows of A = row index, B all 1, requester 1 -> every C[i][j]=8*i; o_done=10, o_err=00.
//  - Both requesters pulse in the same cycle after reset -> grant order 01 then 10.
//    A second simultaneous pulse -> 01 again (ptr wrap).
//    Each requester receives its own C.
//  - Stub engine that never signals done, TIMEOUT=16 -> o_err=o_done=01 at exactly 16 WAIT cycles.
//    o_mat_c unchanged; the next queued job then runs normally.
//  - i_req[0] pulsed on the same cycle it is granted -> a second job for requester 0 runs.
//    Extra pulses during pending do not create a third job.
//  - i_rst during WAIT -> all outputs 0 next cycle.
//    A stray i_mm_done in IDLE produces no o_done.

Source files
------------

// File: rtl/mat_mul_pkg.sv
// Shared constants for the mat_mul engine and its scheduler: element and
// matrix geometry, scheduler state encodings and an element accessor.
package mat_mul_pkg;

  localparam int DATA_LEN = 32;
  localparam int M        = 8;
  localparam int N        = 8;
  localparam int K        = 8;
  localparam int ROW_SIZE = DATA_LEN * K;
  localparam int MAT_SIZE = DATA_LEN * M * K;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Row-major element (row, col) of a flattened matrix, element 0 in the LSBs.
  function automatic logic signed [DATA_LEN-1:0] mat_elem(
    input logic [MAT_SIZE-1:0] mat,
    input int                  row,
    input int                  col
  );
    return mat[row*ROW_SIZE + col*DATA_LEN +: DATA_LEN];
  endfunction

endpackage

// File: rtl/mat_mul_sched_rr_arbiter.sv
// Round-robin pick among pending requesters: the first set bit at or after
// the pointer wins, wrapping to the lowest set bit below it otherwise.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_pend,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_next_ptr
);

  logic             hi_v;
  logic             lo_v;
  logic [PTR_W-1:0] hi_i;
  logic [PTR_W-1:0] lo_i;
  logic [PTR_W-1:0] sel;

  // Scan downward so the lowest matching index is the one left standing,
  // tracking both "at or after ptr" and "anywhere" candidates.
  always_comb begin
    hi_v = 1'b0;
    lo_v = 1'b0;
    hi_i = '0;
    lo_i = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (i_pend[j]) begin
        lo_v = 1'b1;
        lo_i = PTR_W'(j);
        if (j >= int'(i_ptr)) begin
          hi_v = 1'b1;
          hi_i = PTR_W'(j);
        end
      end
    end
    sel     = hi_v ? hi_i : lo_i;
    o_valid = lo_v;
    o_grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (lo_v && (sel == PTR_W'(j))) o_grant[j] = 1'b1;
    end
    o_next_ptr = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  end

endmodule

// File: rtl/mat_mul_sched.sv
// Shares one mat_mul engine among NUM_REQ requesters: queues job pulses,
// grants round-robin, launches the engine, returns C or aborts on timeout.
module mat_mul_sched
  import mat_mul_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*MAT_SIZE-1:0] i_req_mat_a,
  input  logic [NUM_REQ*MAT_SIZE-1:0] i_req_mat_b,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic [NUM_REQ-1:0]          o_done,
  output logic [NUM_REQ-1:0]          o_err,
  output logic [MAT_SIZE-1:0]         o_mat_c,
  output logic                        o_busy,
  output logic                        o_mm_start,
  output logic [MAT_SIZE-1:0]         o_mm_mat_a,
  output logic [MAT_SIZE-1:0]         o_mm_mat_b,
  input  logic                        i_mm_done,
  input  logic [MAT_SIZE-1:0]         i_mm_mat_c
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]          state_q, state_d;
  logic [NUM_REQ-1:0]  pend_q, pend_d;
  logic [NUM_REQ-1:0]  pend_clr;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [MAT_SIZE-1:0] mat_c_q, mat_c_d;
  logic [MAT_SIZE-1:0] mm_a_q, mm_a_d;
  logic [MAT_SIZE-1:0] mm_b_q, mm_b_d;

  logic                arb_valid;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [PTR_W-1:0]    arb_next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_pend     (pend_q),
    .i_ptr      (ptr_q),
    .o_valid    (arb_valid),
    .o_grant    (arb_grant),
    .o_next_ptr (arb_next_ptr)
  );

  // Next-state logic: FSM, pending set/clear, operand latch and watchdog.
  always_comb begin
    state_d  = state_q;
    pend_clr = '0;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = '0;
    mat_c_d  = mat_c_q;
    mm_a_d   = mm_a_q;
    mm_b_d   = mm_b_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          for (int r = 0; r < NUM_REQ; r++) begin
            if (arb_grant[r]) begin
              mm_a_d = i_req_mat_a[r*MAT_SIZE +: MAT_SIZE];
              mm_b_d = i_req_mat_b[r*MAT_SIZE +: MAT_SIZE];
            end
          end
          grant_d  = arb_grant;
          pend_clr = arb_grant;
          ptr_d    = arb_next_ptr;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A real result beats a timeout landing on the same cycle.
        if (i_mm_done) begin
          mat_c_d = i_mm_mat_c;
          done_d  = grant_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          done_d  = grant_q;
          err_d   = grant_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    // A new pulse on the grant cycle re-queues the requester.
    pend_d = (pend_q & ~pend_clr) | i_req;
  end

  // State registers; reset abandons any job in flight and clears all outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      mat_c_q <= '0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mat_c_q <= mat_c_d;
      mm_a_q  <= mm_a_d;
      mm_b_q  <= mm_b_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_mat_c    = mat_c_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_mm_start = (state_q == ST_START);
  assign o_mm_mat_a = mm_a_q;
  assign o_mm_mat_b = mm_b_q;

endmodule

// File: tb/tb_mat_mul_sched.sv
// Directed bench for mat_mul_sched with a behavioural engine model.
module tb_mat_mul_sched;
  import mat_mul_pkg::*;

  localparam int NREQ = 2;
  localparam int TMO  = 16;

  logic                     clk = 1'b0;
  logic                     i_rst;
  logic [NREQ-1:0]          i_req;
  logic [NREQ*MAT_SIZE-1:0] req_a, req_b;
  logic [NREQ-1:0]          o_grant, o_done, o_err;
  logic [MAT_SIZE-1:0]      o_mat_c, o_mm_mat_a, o_mm_mat_b;
  logic                     o_busy, o_mm_start;
  logic                     mm_done;
  logic                     eng_done, stray_done, eng_en;
  logic [MAT_SIZE-1:0]      eng_c, eng_prod;
  int                       eng_lat;

  int checks = 0;
  int errs   = 0;
  int n_done0 = 0, n_done_any = 0, n_errp = 0;

  assign mm_done = eng_done | stray_done;

  mat_mul_sched #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req),
    .i_req_mat_a(req_a), .i_req_mat_b(req_b),
    .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_mat_c(o_mat_c),
    .o_busy(o_busy), .o_mm_start(o_mm_start),
    .o_mm_mat_a(o_mm_mat_a), .o_mm_mat_b(o_mm_mat_b),
    .i_mm_done(mm_done), .i_mm_mat_c(eng_c)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Build a matrix whose element (i,j) is base + mul*i.
  function automatic logic [MAT_SIZE-1:0] mk(input int base, input int mul);
    logic [MAT_SIZE-1:0] m;
    m = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < K; j++)
        m[i*ROW_SIZE + j*DATA_LEN +: DATA_LEN] = DATA_LEN'(base + mul*i);
    return m;
  endfunction

  function automatic logic [MAT_SIZE-1:0] matmul(input logic [MAT_SIZE-1:0] a,
                                                 input logic [MAT_SIZE-1:0] b);
    logic [MAT_SIZE-1:0]       c;
    logic signed [DATA_LEN-1:0] acc;
    c = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < K; k++) acc = acc + mat_elem(a, i, k) * mat_elem(b, k, j);
        c[i*ROW_SIZE + j*DATA_LEN +: DATA_LEN] = acc;
      end
    return c;
  endfunction

  function automatic logic [MAT_SIZE-1:0] rnd_mat();
    logic [MAT_SIZE-1:0] m;
    for (int w = 0; w < MAT_SIZE/32; w++) m[w*32 +: 32] = $urandom;
    return m;
  endfunction

  // Engine model: result appears eng_lat cycles after the start cycle.
  initial begin
    eng_done = 1'b0;
    eng_c    = '0;
    forever begin
      @(posedge clk); #1;
      if (o_mm_start && eng_en) begin
        eng_prod = matmul(o_mm_mat_a, o_mm_mat_b);
        repeat (eng_lat) @(posedge clk);
        #1;
        eng_c    = eng_prod;
        eng_done = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (o_done[0]) n_done0 = n_done0 + 1;
    if (|o_done)   n_done_any = n_done_any + 1;
    if (|o_err)    n_errp = n_errp + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_mat(input string name, input logic [MAT_SIZE-1:0] act,
                           input logic [MAT_SIZE-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int e = 0; e < M*K; e++)
      if (bad < 0 && act[e*DATA_LEN +: DATA_LEN] !== exp[e*DATA_LEN +: DATA_LEN]) bad = e;
    if (bad >= 0) begin
      errs++;
      $display("FAIL %s: elem %0d got %0d expected %0d", name, bad,
               $signed(act[bad*DATA_LEN +: DATA_LEN]), $signed(exp[bad*DATA_LEN +: DATA_LEN]));
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // k counts negedges from the call; returns -1 if the bound expires.
  task automatic wait_start(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_mm_start) begin n = k; break; end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (|o_done) begin n = k; break; end
    end
  endtask

  typedef struct {
    logic [1:0] req;
    int a_base, a_mul, b_base, b_mul;
    int c_base, c_mul;
    logic [1:0] grant;
    int lat;
  } vec_t;

  vec_t vecs[4];
  logic [MAT_SIZE-1:0] a, b, exp_last;
  int n, b0, ba, be;

  initial begin
    vecs[0] = '{2'b01,  1, 0, 0, 1,  28,  0, 2'b01, 2};
    vecs[1] = '{2'b10,  0, 1, 1, 0,   0,  8, 2'b10, 3};
    vecs[2] = '{2'b01,  0, 1, 0, 1,   0, 28, 2'b01, 1};
    vecs[3] = '{2'b10, -3, 0, 0, 1, -84,  0, 2'b10, 5};

    i_rst = 1'b1; i_req = '0; req_a = '0; req_b = '0;
    stray_done = 1'b0; eng_en = 1'b1; eng_lat = 2;
    exp_last = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst grant", o_grant, 0);
    check("rst done", o_done, 0);
    check("rst err", o_err, 0);
    check("rst busy", o_busy, 0);
    check("rst start", o_mm_start, 0);
    check_mat("rst mat_c", o_mat_c, '0);
    check_mat("rst mm_a", o_mm_mat_a, '0);
    tick();
    i_rst = 1'b0;

    // Single jobs from the vector table
    for (int v = 0; v < 4; v++) begin
      eng_lat = vecs[v].lat;
      a = mk(vecs[v].a_base, vecs[v].a_mul);
      b = mk(vecs[v].b_base, vecs[v].b_mul);
      req_a = {a, a};
      req_b = {b, b};
      i_req = vecs[v].req;
      tick();
      i_req = '0;
      wait_start(n);
      check($sformatf("v%0d start latency", v), n, 2);
      check($sformatf("v%0d grant", v), o_grant, vecs[v].grant);
      check($sformatf("v%0d busy", v), o_busy, 1);
      check_mat($sformatf("v%0d mm_a", v), o_mm_mat_a, a);
      check_mat($sformatf("v%0d mm_b", v), o_mm_mat_b, b);
      req_a = {rnd_mat(), rnd_mat()};
      req_b = {rnd_mat(), rnd_mat()};
      wait_done(n);
      check($sformatf("v%0d done latency", v), n, vecs[v].lat + 1);
      check($sformatf("v%0d done", v), o_done, vecs[v].req);
      check($sformatf("v%0d err", v), o_err, 0);
      check($sformatf("v%0d grant drop", v), o_grant, 0);
      exp_last = mk(vecs[v].c_base, vecs[v].c_mul);
      check_mat($sformatf("v%0d C", v), o_mat_c, exp_last);
      tick();
    end

    // Simultaneous requests after reset: order 01, 10, then wrap to 01
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    eng_lat = 2;
    req_a = {mk(0, 1), mk(1, 0)};
    req_b = {mk(1, 0), mk(0, 1)};
    i_req = 2'b11; tick(); i_req = '0;
    wait_start(n);
    check("sim1 start latency", n, 2);
    check("sim1 grant0", o_grant, 2'b01);
    wait_done(n);
    check("sim1 done0", o_done, 2'b01);
    check_mat("sim1 C0", o_mat_c, mk(28, 0));
    @(negedge clk);
    check("sim1 back-to-back start", o_mm_start, 1);
    check("sim1 grant1", o_grant, 2'b10);
    wait_done(n);
    check("sim1 done1", o_done, 2'b10);
    check_mat("sim1 C1", o_mat_c, mk(0, 8));
    tick();
    i_req = 2'b11; tick(); i_req = '0;
    wait_start(n);
    check("sim2 grant0", o_grant, 2'b01);
    wait_done(n);
    check("sim2 done0", o_done, 2'b01);
    wait_start(n);
    check("sim2 idle gap", n, 1);
    check("sim2 grant1", o_grant, 2'b10);
    wait_done(n);
    check("sim2 done1", o_done, 2'b10);
    exp_last = mk(0, 8);

    // Watchdog abort, then the queued job runs normally
    tick();
    eng_en = 1'b0;
    req_a = {mk(0, 1), mk(5, 0)};
    req_b = {mk(0, 1), mk(0, 1)};
    i_req = 2'b11; tick(); i_req = '0;
    wait_start(n);
    check("tmo grant", o_grant, 2'b01);
    wait_done(n);
    check("tmo wait cycles", n, TMO + 1);
    check("tmo done", o_done, 2'b01);
    check("tmo err", o_err, 2'b01);
    check("tmo grant drop", o_grant, 0);
    check_mat("tmo C kept", o_mat_c, exp_last);
    eng_en = 1'b1;
    wait_start(n);
    check("tmo next start", n, 1);
    check("tmo next grant", o_grant, 2'b10);
    wait_done(n);
    check("tmo next done", o_done, 2'b10);
    check("tmo next err", o_err, 0);
    check_mat("tmo next C", o_mat_c, mk(0, 28));

    // Re-queue on the grant cycle; extra pulses while pending are absorbed
    tick();
    eng_lat = 2;
    req_a = {mk(0, 0), mk(1, 0)};
    req_b = {mk(0, 0), mk(0, 1)};
    b0 = n_done0; ba = n_done_any;
    i_req = 2'b01; tick();
    i_req = 2'b01; tick();
    i_req = 2'b00; tick();
    i_req = 2'b01; tick();
    i_req = 2'b01; tick();
    i_req = 2'b00;
    repeat (40) @(negedge clk);
    check("requeue jobs req0", n_done0 - b0, 2);
    check("requeue jobs total", n_done_any - ba, 2);
    check("requeue idle", o_busy, 0);
    check_mat("requeue C", o_mat_c, mk(28, 0));

    // Reset in WAIT abandons the job silently
    tick();
    eng_en = 1'b0;
    i_req = 2'b01; tick(); i_req = '0;
    wait_start(n);
    check("rstw start", n, 2);
    tick(); tick();
    check("rstw in wait", o_busy, 1);
    ba = n_done_any; be = n_errp;
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    @(negedge clk);
    check("rstw grant", o_grant, 0);
    check("rstw busy", o_busy, 0);
    check("rstw start", o_mm_start, 0);
    check("rstw done", o_done, 0);
    check("rstw err", o_err, 0);
    check_mat("rstw mat_c", o_mat_c, '0);
    check_mat("rstw mm_a", o_mm_mat_a, '0);
    repeat (25) @(negedge clk);
    check("rstw no done", n_done_any - ba, 0);
    check("rstw no err", n_errp - be, 0);

    // Stray engine done while idle
    tick();
    stray_done = 1'b1; tick(); stray_done = 1'b0;
    @(negedge clk);
    check("stray done", o_done, 0);
    check("stray busy", o_busy, 0);
    repeat (3) @(negedge clk);
    check("stray no done", n_done_any - ba, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
